// File: rtl/modrm_pkg.sv
// rtl/modrm_pkg.sv - shared state encoding, ModRM field constants and displacement-length rule
package modrm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MODRM,
        DISP_LO,
        DISP_HI,
        START,
        WAIT
    } state_t;

    localparam logic [1:0] MOD_REG   = 2'b11;
    localparam logic [2:0] RM_DIRECT = 3'b110;

    // Number of displacement bytes that follow a given ModRM byte (0, 1 or 2).
    function automatic logic [1:0] disp_len(input logic [7:0] modrm_byte);
        logic [1:0] len;
        unique case (modrm_byte[7:6])
            2'b00:   len = (modrm_byte[2:0] == RM_DIRECT) ? 2'd2 : 2'd0;
            2'b01:   len = 2'd1;
            2'b10:   len = 2'd2;
            MOD_REG: len = 2'd0;
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/modrm_disp_assembler.sv
// rtl/modrm_disp_assembler.sv - byte-lane loading and sign extension of the 16-bit displacement
module modrm_disp_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero_i,
    input  logic        load_lo_i,
    input  logic        load_hi_i,
    input  logic        sext_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] disp_o
);

    logic [15:0] disp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q <= 16'h0000;
        end else if (zero_i) begin
            disp_q <= 16'h0000;
        end else begin
            if (load_lo_i) begin
                disp_q[7:0] <= byte_i;
                if (sext_i) begin
                    disp_q[15:8] <= {8{byte_i[7]}};
                end
            end
            if (load_hi_i) begin
                disp_q[15:8] <= byte_i;
            end
        end
    end

    assign disp_o = disp_q;

endmodule

// File: rtl/modrm_fetch_sequencer.sv
// rtl/modrm_fetch_sequencer.sv - ModRM operand fetch sequencer; MODRM_BYTECOUNT_EN adds bytes_consumed
module modrm_fetch_sequencer
    import modrm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        begin_fetch,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_en,
    output logic [7:0]  modrm,
    output logic [15:0] displacement,
    output logic        modrm_start,
    output logic        modrm_clear,
    output logic        busy,
    output logic        complete
`ifdef MODRM_BYTECOUNT_EN
    ,
    output logic [1:0]  bytes_consumed
`endif
);

    state_t     state_q, state_d;
    logic [7:0] modrm_q;
    logic       start_q, clear_q, busy_q, complete_q;
    logic       rd_en, ld_modrm, ld_zero, ld_lo, ld_hi, ld_sext;
    logic [1:0] len_head, len_latched;

    assign len_head    = disp_len(fifo_rd_data);
    assign len_latched = disp_len(modrm_q);

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        ld_modrm = 1'b0;
        ld_zero  = 1'b0;
        ld_lo    = 1'b0;
        ld_hi    = 1'b0;
        ld_sext  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (begin_fetch) state_d = MODRM;
            end
            MODRM: begin
                if (!fifo_empty) begin
                    rd_en    = 1'b1;
                    ld_modrm = 1'b1;
                    if (len_head == 2'd0) begin
                        ld_zero = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = DISP_LO;
                    end
                end
            end
            DISP_LO: begin
                if (!fifo_empty) begin
                    rd_en = 1'b1;
                    ld_lo = 1'b1;
                    if (len_latched == 2'd1) begin
                        ld_sext = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = DISP_HI;
                    end
                end
            end
            DISP_HI: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    ld_hi   = 1'b1;
                    state_d = START;
                end
            end
            START:   state_d = WAIT;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush (and reset) must never consume a byte or disturb the latched operand.
        if (flush || reset) begin
            state_d  = IDLE;
            rd_en    = 1'b0;
            ld_modrm = 1'b0;
            ld_zero  = 1'b0;
            ld_lo    = 1'b0;
            ld_hi    = 1'b0;
            ld_sext  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            modrm_q    <= 8'h00;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (ld_modrm) modrm_q <= fifo_rd_data;
            start_q    <= (state_q == START) && !flush;
            complete_q <= (state_q == WAIT) && !flush;
            clear_q    <= flush && (state_q != IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    modrm_disp_assembler u_disp (
        .clk       (clk),
        .reset     (reset),
        .zero_i    (ld_zero),
        .load_lo_i (ld_lo),
        .load_hi_i (ld_hi),
        .sext_i    (ld_sext),
        .byte_i    (fifo_rd_data),
        .disp_o    (displacement)
    );

`ifdef MODRM_BYTECOUNT_EN
    logic [1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= 2'd0;
        end else if (state_q == IDLE && begin_fetch) begin
            count_q <= 2'd0;
        end else if (rd_en) begin
            count_q <= count_q + 2'd1;
        end
    end

    assign bytes_consumed = count_q;
`endif

    assign fifo_rd_en  = rd_en;
    assign modrm       = modrm_q;
    assign modrm_start = start_q;
    assign modrm_clear = clear_q;
    assign busy        = busy_q;
    assign complete    = complete_q;

endmodule

// File: tb/tb_modrm_fetch_sequencer.sv
// tb/tb_modrm_fetch_sequencer.sv - scoreboard bench for modrm_fetch_sequencer
module tb_modrm_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, begin_fetch, flush, fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en, modrm_start, modrm_clear, busy, complete;
    logic [7:0]  modrm;
    logic [15:0] displacement;
`ifdef MODRM_BYTECOUNT_EN
    logic [1:0]  bytes_consumed;
`endif

    always #5 clk = ~clk;

    modrm_fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .begin_fetch  (begin_fetch),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .modrm        (modrm),
        .displacement (displacement),
        .modrm_start  (modrm_start),
        .modrm_clear  (modrm_clear),
        .busy         (busy),
        .complete     (complete)
`ifdef MODRM_BYTECOUNT_EN
        ,
        .bytes_consumed (bytes_consumed)
`endif
    );

    typedef struct {
        logic [7:0]  m;
        logic [15:0] d;
        int          lat;
        int          nb;
        int          bcyc;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [7:0] fq[$];
    int         gaps[$];
    int         gap = 0;
    int         pops = 0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_clear = 0;
    int         act_clear = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference rules: displacement length and value straight from mod/rm.
    function automatic int ref_len(input logic [7:0] m);
        case (m[7:6])
            2'b00:   return (m[2:0] == 3'b110) ? 2 : 0;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] ref_disp(input logic [7:0] m, input logic [7:0] b1, input logic [7:0] b2);
        int v;
        case (ref_len(m))
            0: v = 0;
            1: begin v = int'(b1); if (v >= 128) v = v - 256; end
            default: v = int'(b2) * 256 + int'(b1);
        endcase
        return 16'(v);
    endfunction

    task automatic update_fifo();
        fifo_empty   = (gap > 0) || (fq.size() == 0);
        fifo_rd_data = (fq.size() > 0) ? fq[0] : 8'h5A;
    endtask

    task automatic tick();
        logic p;
        @(negedge clk);
        p = fifo_rd_en;
        @(posedge clk);
        #1;
        begin_fetch = 1'b0;
        flush       = 1'b0;
        reset       = 1'b0;
        if (p) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
            gap = (gaps.size() > 0) ? gaps.pop_front() : 0;
        end else if (gap > 0) begin
            gap--;
        end
        update_fifo();
    endtask

    task automatic start_op(input logic [7:0] m, input logic [7:0] b1, input logic [7:0] b2,
                            input int s0, input int s1, input int s2);
        int n;
        exp_t x;
        n = 1 + ref_len(m);
        fq.delete();
        gaps.delete();
        fq.push_back(m);
        if (n > 1) begin fq.push_back(b1); gaps.push_back(s1); end
        if (n > 2) begin fq.push_back(b2); gaps.push_back(s2); end
        gap = s0 + 1;
        pops = 0;
        update_fifo();
        x.m    = m;
        x.d    = ref_disp(m, b1, b2);
        x.nb   = n;
        x.lat  = 3 + n + s0 + ((n > 1) ? s1 : 0) + ((n > 2) ? s2 : 0);
        x.bcyc = cyc;
        expq.push_back(x);
        begin_fetch = 1'b1;
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] b1, input logic [7:0] b2,
                          input int s0, input int s1, input int s2);
        start_op(m, b1, b2, s0, s1, s2);
        for (int i = 0; i < 80 && expq.size() > 0; i++) tick();
        if (expq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no complete within 80 cycles for modrm %0h", m);
            expq.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        check({tag, "_modrm"}, 32'(modrm), 0);
        check({tag, "_disp"}, 32'(displacement), 0);
        check({tag, "_start"}, 32'(modrm_start), 0);
        check({tag, "_clear"}, 32'(modrm_clear), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_complete"}, 32'(complete), 0);
`ifdef MODRM_BYTECOUNT_EN
        check({tag, "_bytes"}, 32'(bytes_consumed), 0);
`endif
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 30 && pops < target; i++) tick();
        check("wait_pops", 32'(pops), 32'(target));
    endtask

    // Monitor: pops the scoreboard whenever the DUT announces an operand.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_rd_en) check("rd_en_legal", 32'(fifo_empty | flush), 0);
            if (modrm_clear) act_clear++;
            if (modrm_start) begin
                if (expq.size() == 0) begin
                    check("unexpected_start", 32'(modrm_start), 0);
                end else begin
                    check("start_time", 32'(cyc), 32'(expq[0].bcyc + expq[0].lat - 1));
                    check("start_modrm", 32'(modrm), 32'(expq[0].m));
                    check("start_disp", 32'(displacement), 32'(expq[0].d));
                end
            end
            if (complete) begin
                if (expq.size() == 0) begin
                    check("unexpected_complete", 32'(complete), 0);
                end else begin
                    e = expq.pop_front();
                    check("latency", 32'(cyc - e.bcyc), 32'(e.lat));
                    check("modrm", 32'(modrm), 32'(e.m));
                    check("disp", 32'(displacement), 32'(e.d));
                    check("pops", 32'(pops), 32'(e.nb));
                    check("busy_at_complete", 32'(busy), 0);
`ifdef MODRM_BYTECOUNT_EN
                    check("bytes_consumed", 32'(bytes_consumed), 32'(e.nb));
`endif
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        begin_fetch = 1'b0;
        flush = 1'b0;
        update_fifo();
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(8'hC3, 8'h00, 8'h00, 0, 0, 0);
        run_op(8'h46, 8'hFE, 8'h00, 0, 0, 0);
        run_op(8'h06, 8'h34, 8'h12, 0, 0, 0);
        run_op(8'h85, 8'hCD, 8'hAB, 0, 0, 3);
        run_op(8'h07, 8'h00, 8'h00, 2, 0, 0);
        run_op(8'h4D, 8'h7F, 8'h00, 0, 1, 0);

        // Flush while waiting for the high displacement byte.
        start_op(8'h86, 8'h11, 8'h22, 0, 0, 10);
        expq.delete();
        tick();
        wait_pops(2);
        flush = 1'b1;
        tick();
        exp_clear++;
        check("flush_clear", 32'(modrm_clear), 1);
        check("flush_busy", 32'(busy), 0);
        check("flush_modrm_kept", 32'(modrm), 32'h86);
        check("flush_disp_lo_kept", 32'(displacement[7:0]), 32'h11);
        for (int i = 0; i < 4; i++) tick();
        fq.delete(); gaps.delete(); gap = 0; update_fifo();

        // begin_fetch together with flush in IDLE is dropped.
        begin_fetch = 1'b1;
        flush = 1'b1;
        tick();
        check("idle_flush_clear", 32'(modrm_clear), 0);
        check("idle_flush_busy", 32'(busy), 0);
        tick();
        check("idle_flush_busy2", 32'(busy), 0);

        // Reset while waiting for the displacement byte.
        start_op(8'h46, 8'h7F, 8'h00, 0, 10, 0);
        tick();
        wait_pops(1);
        expq.delete();
        reset = 1'b1;
        tick();
        check_zero("mid_reset");
        fq.delete(); gaps.delete(); gap = 0; update_fifo();
        run_op(8'h46, 8'h80, 8'h00, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] m, b1, b2;
            int s0, s1, s2;
            m  = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            s0 = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            s1 = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            s2 = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            run_op(m, b1, b2, s0, s1, s2);
        end

        tick();
        check("clear_count", 32'(act_clear), 32'(exp_clear));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
